z_drain: RTL and testbench

Z_DRAIN -- requirements
Module: z_drain

---
 rtl/z_drain_pkg.sv | 19 +
 rtl/z_drain_if.sv | 35 +++
 rtl/z_drain_fifo.sv | 59 +++++
 rtl/z_drain.sv | 136 +++++++++++++
 tb/tb_z_drain.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z_drain_pkg.sv
// matmul_pkg: definitions shared by the Z-drain block and its testbench.
//   drain_state_t : drain FSM encoding (IDLE, STREAM, FLUSH, FIN)
//   DATA_WIDTH    : default result word width
//   ADDR_WIDTH    : default Z-memory address width
//   TN            : default matrix dimension (TN*TN words are drained)
package matmul_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 6;
    localparam int TN         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        FIN    = 2'd3
    } drain_state_t;

endpackage

// File: rtl/z_drain_if.sv
// z_drain_if: Z-memory read port plus the output stream of the drain block.
//   z_addr, z_rd_en : read request (drain -> memory)
//   z_dout          : read data, valid exactly one cycle after z_rd_en
//   m_data, m_valid, m_row_end, m_last : output stream word and its flags
//   m_ready         : downstream accept
//
// Handshake: a word transfers on a rising edge where m_valid and m_ready are
// both high; once m_valid is raised, m_valid, m_data, m_row_end and m_last
// hold their values until that transfer happens, and m_valid never waits on
// m_ready.
interface z_drain_if #(
    parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] z_addr;
    logic                  z_rd_en;
    logic [DATA_WIDTH-1:0] z_dout;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_row_end;
    logic                  m_last;

    // Drain side.
    modport master (
        output z_addr, z_rd_en, m_data, m_valid, m_row_end, m_last,
        input  z_dout, m_ready
    );

    // Memory / downstream side.
    modport slave (
        input  z_addr, z_rd_en, m_data, m_valid, m_row_end, m_last,
        output z_dout, m_ready
    );
endinterface

// File: rtl/z_drain_fifo.sv
// stream_fifo2: two-entry synchronous FIFO for stream words.
//   clk, rst_n   : clock and synchronous active-low reset (clears contents)
//   push_i       : write push_data_i (accepted when not full, or when full
//                  and a pop happens in the same cycle)
//   pop_i        : remove the head word (ignored when empty)
//   pop_data_o   : head word, stable until popped
//   full_o       : two words held
//   empty_o      : no words held
// A push and a pop in the same cycle leave occupancy unchanged.
module stream_fifo2 #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop     = pop_i && (count_q != 2'd0);
    assign do_push    = push_i && ((count_q != 2'd2) || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/z_drain.sv
// z_drain: streams a Tn x Tn result matrix out of Z-memory in row-major order.
//   clock     : rising-edge clock
//   reset     : synchronous active-low reset; aborts any drain in progress
//   start     : one-cycle pulse, begins a drain when IDLE
//   busy      : high from the accepted start until done
//   done      : one-cycle pulse when the last word has been accepted
//   state_dbg : current FSM state
//   bus       : Z-memory read port and output stream (z_drain_if.master)
//
// Reads go to a 2-entry FIFO together with their row-end/last flags, so the
// flags are decided at read time and simply travel with the word.
module z_drain
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = matmul_pkg::ADDR_WIDTH,
    parameter int Tn         = matmul_pkg::TN
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output drain_state_t state_dbg,
    z_drain_if.master    bus
);

    localparam int FW = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(Tn * Tn - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(Tn - 1);

    drain_state_t          state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] col_q;
    logic                  inflight_q;
    logic                  infl_row_end_q;
    logic                  infl_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [FW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [2:0]            occ;
    logic [2:0]            committed;
    logic                  rd_en;

    assign occ = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
    assign pop = !fifo_empty && bus.m_ready;

    // Slots already spoken for: words held plus the read whose data is on
    // z_dout now. A word popped this cycle frees its slot a full cycle before
    // a read issued now can land, so it is credited back; this is what lets
    // the stream run at one word per cycle with only two entries.
    assign committed = occ - 3'(pop) + 3'(inflight_q);
    assign rd_en     = (state_q == STREAM) && (committed < 3'd2);

    assign bus.z_rd_en   = rd_en;
    assign bus.z_addr    = rd_en ? addr_q : '0;
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_data    = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign bus.m_row_end = !fifo_empty && fifo_head[FW-1];
    assign bus.m_last    = !fifo_empty && fifo_head[FW-2];

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

    stream_fifo2 #(.W(FW)) u_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .push_i      (inflight_q),
        .push_data_i ({infl_row_end_q, infl_last_q, bus.z_dout}),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            col_q          <= '0;
            inflight_q     <= 1'b0;
            infl_row_end_q <= 1'b0;
            infl_last_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            // The read issued this cycle returns next cycle and is pushed then.
            inflight_q <= rd_en;
            if (rd_en) begin
                infl_row_end_q <= (col_q == LAST_COL);
                infl_last_q    <= (addr_q == LAST_ADDR);
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= STREAM;
                        addr_q  <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= FLUSH;
                        end else begin
                            addr_q <= addr_q + ADDR_WIDTH'(1);
                            col_q  <= (col_q == LAST_COL) ? '0 : col_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (pop && fifo_head[FW-2]) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z_drain.sv
// Testbench for z_drain: a Tn=8 instance over a z[a]=a+100 memory and a Tn=2
// instance over z={-1,0,5,7}. Expected words go into queues when a drain is
// started; forked monitors pop and compare on every transfer.
module tb_z_drain;
  import matmul_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int FW = DW + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic start2;
  logic busy, done, busy2, done2;
  drain_state_t state_dbg, state_dbg2;

  z_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  z_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  z_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Tn(8)) dut (
    .clock(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
    .state_dbg(state_dbg), .bus(bus)
  );

  z_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Tn(2)) dut2 (
    .clock(clk), .reset(rst_n), .start(start2), .busy(busy2), .done(done2),
    .state_dbg(state_dbg2), .bus(bus2)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem2 [4];

  always @(posedge clk) begin
    if (bus.z_rd_en) bus.z_dout <= DW'(bus.z_addr) + 32'd100;
    if (bus2.z_rd_en) bus2.z_dout <= mem2[bus2.z_addr[1:0]];
  end

  // ---------------- scoreboard state ----------------
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp2_q[$];
  int checks = 0;
  int failures = 0;
  int xfer_cnt, done_cnt, rd_cnt, first_cyc, last_cyc;
  int xfer2_cnt, done2_cnt;

  task automatic check(input string name, input logic ok,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected word: {row_end, last, data}, data = z[a].
  task automatic push_big();
    for (int a = 0; a < 64; a++)
      exp_q.push_back({(a % 8) == 7, a == 63, DW'(a + 100)});
  endtask

  // ---------------- monitors ----------------
  task automatic mon_big();
    logic [FW-1:0] got, held, req;
    logic stalled;
    logic last_xfer;
    stalled = 1'b0;
    last_xfer = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        got = {bus.m_row_end, bus.m_last, bus.m_data};
        if (stalled)
          check("hold_stable", bus.m_valid && got == held, {bus.m_valid, got}, {1'b1, held});
        if (last_xfer)
          check("done_after_last", done && !busy, {done, busy}, 2'b10);
        if (!bus.z_rd_en)
          check("z_addr_idle_zero", bus.z_addr == '0, bus.z_addr, 0);
        if (done) done_cnt++;
        if (bus.z_rd_en) rd_cnt++;
        last_xfer = 1'b0;
        if (bus.m_valid && bus.m_ready) begin
          check("queue_nonempty", exp_q.size() != 0, exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            req = exp_q.pop_front();
            check("word", got == req, got, req);
          end
          xfer_cnt++;
          if (xfer_cnt == 1) first_cyc = cyc;
          last_cyc = cyc;
          last_xfer = bus.m_last;
        end
        stalled = bus.m_valid && !bus.m_ready;
        held = got;
      end else begin
        stalled = 1'b0;
        last_xfer = 1'b0;
      end
    end
  endtask

  task automatic mon_small();
    logic [FW-1:0] got, req;
    logic last_xfer;
    last_xfer = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        got = {bus2.m_row_end, bus2.m_last, bus2.m_data};
        if (last_xfer)
          check("done2_after_last", done2 && !busy2, {done2, busy2}, 2'b10);
        if (done2) done2_cnt++;
        last_xfer = 1'b0;
        if (bus2.m_valid && bus2.m_ready) begin
          check("queue2_nonempty", exp2_q.size() != 0, exp2_q.size(), 1);
          if (exp2_q.size() != 0) begin
            req = exp2_q.pop_front();
            check("word_tn2", got == req, got, req);
          end
          xfer2_cnt++;
          last_xfer = bus2.m_last;
        end
      end else begin
        last_xfer = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic clear_counts();
    xfer_cnt = 0; done_cnt = 0; rd_cnt = 0; first_cyc = 0; last_cyc = 0;
  endtask

  // Waits for done (sampled at negedge); optionally toggles m_ready each cycle.
  task automatic wait_done(input int budget, input logic toggle);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      if (toggle) bus.m_ready = ~bus.m_ready;
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, done, 1);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfer_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("xfer_wait_timeout", xfer_cnt >= target, xfer_cnt, target);
  endtask

  task automatic end_of_drain(input string name);
    check({name, "_count"}, xfer_cnt == 64, xfer_cnt, 64);
    check({name, "_done_pulses"}, done_cnt == 1, done_cnt, 1);
    check({name, "_queue_empty"}, exp_q.size() == 0, exp_q.size(), 0);
    check({name, "_idle"}, state_dbg == IDLE && !busy && !done,
          {state_dbg, busy, done}, {IDLE, 2'b00});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    bus.m_ready = 1'b1;
    bus2.m_ready = 1'b1;
    mem2[0] = 32'hFFFF_FFFF;
    mem2[1] = 32'd0;
    mem2[2] = 32'd5;
    mem2[3] = 32'd7;
    clear_counts();
    xfer2_cnt = 0;
    done2_cnt = 0;
    fork
      mon_big();
      mon_small();
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {busy, done, bus.z_rd_en, bus.m_valid, bus.m_row_end, bus.m_last} == 6'b0,
          {busy, done, bus.z_rd_en, bus.m_valid, bus.m_row_end, bus.m_last}, 0);
    check("rst_z_addr", bus.z_addr == '0, bus.z_addr, 0);
    check("rst_m_data", bus.m_data == '0, bus.m_data, 0);
    check("rst_state", state_dbg == IDLE, state_dbg, IDLE);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: full-rate drain, first m_valid two edges after start.
    clear_counts();
    push_big();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, busy, 1);
    check("valid_edge1", !bus.m_valid, bus.m_valid, 0);
    @(negedge clk);
    check("valid_edge1b", !bus.m_valid, bus.m_valid, 0);
    @(negedge clk);
    check("valid_edge2", bus.m_valid, bus.m_valid, 1);
    wait_done(200, 1'b0);
    end_of_drain("t1");
    check("t1_back_to_back", last_cyc - first_cyc == 63, last_cyc - first_cyc, 63);

    // 2: m_ready toggling.
    clear_counts();
    push_big();
    pulse_start();
    wait_done(400, 1'b1);
    end_of_drain("t2");

    // 3: m_ready low for 20 cycles after start.
    clear_counts();
    push_big();
    bus.m_ready = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t3_reads_bounded", rd_cnt <= 2, rd_cnt, 2);
    check("t3_valid_held", bus.m_valid, bus.m_valid, 1);
    check("t3_first_word", bus.m_data == 32'd100, bus.m_data, 100);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    wait_done(200, 1'b0);
    end_of_drain("t3");

    // 4: second start while busy is ignored.
    clear_counts();
    push_big();
    pulse_start();
    wait_xfers(10);
    pulse_start();
    check("t4_busy_kept", busy, busy, 1);
    wait_done(200, 1'b0);
    end_of_drain("t4");
    repeat (4) @(negedge clk);
    check("t4_no_second_drain", !busy && xfer_cnt == 64, {busy, xfer_cnt}, 64);

    // 5: one-cycle reset at word 30 aborts; then a full drain.
    clear_counts();
    push_big();
    pulse_start();
    wait_xfers(30);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_ctrl", {busy, done, bus.z_rd_en, bus.m_valid, bus.m_row_end, bus.m_last} == 6'b0,
          {busy, done, bus.z_rd_en, bus.m_valid, bus.m_row_end, bus.m_last}, 0);
    check("t5_rst_data", bus.m_data == '0 && bus.z_addr == '0, {bus.z_addr, bus.m_data}, 0);
    check("t5_rst_state", state_dbg == IDLE, state_dbg, IDLE);
    repeat (6) @(negedge clk);
    check("t5_no_done", done_cnt == 0 && !bus.m_valid, {done_cnt, bus.m_valid}, 0);
    clear_counts();
    push_big();
    pulse_start();
    wait_done(200, 1'b0);
    end_of_drain("t5");

    // 6: Tn=2 instance over signed-looking values.
    exp2_q.push_back({1'b0, 1'b0, 32'hFFFF_FFFF});
    exp2_q.push_back({1'b1, 1'b0, 32'd0});
    exp2_q.push_back({1'b0, 1'b0, 32'd5});
    exp2_q.push_back({1'b1, 1'b1, 32'd7});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    begin
      int n;
      n = 0;
      while (!done2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_done2", done2, done2, 1);
    repeat (2) @(negedge clk);
    check("t6_count", xfer2_cnt == 4, xfer2_cnt, 4);
    check("t6_done_pulses", done2_cnt == 1, done2_cnt, 1);
    check("t6_queue_empty", exp2_q.size() == 0, exp2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
